// File: rtl/bakraid_eeprom_93c66.sv
// 93C66-style Microwire serial EEPROM (256x16) with a parallel NV load/dump port.
// Ports: CLK, RESET_N (async, active low); SCS/SCLK/SDI serial in, SDO data/ready out;
//  NV_ADDR/NV_DIN/NV_WE parallel write, NV_DOUT registered read (1 CLK latency);
//  DIRTY (out) only when EEPROM_DIRTY_EN is defined.
module bakraid_eeprom_93c66 #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int BUSY_CLKS = 64
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              SCS,
  input  logic              SCLK,
  input  logic              SDI,
  output logic              SDO,
  input  logic [ADDR_W-1:0] NV_ADDR,
  input  logic [DATA_W-1:0] NV_DIN,
  input  logic              NV_WE,
`ifdef EEPROM_DIRTY_EN
  output logic [DATA_W-1:0] NV_DOUT,
  output logic              DIRTY
`else
  output logic [DATA_W-1:0] NV_DOUT
`endif
);

  localparam int WORDS   = 1 << ADDR_W;
  localparam int BUSY_SW = (BUSY_CLKS > WORDS) ? BUSY_CLKS : WORDS;
  localparam int BW      = $clog2(BUSY_SW + 1);
  localparam int CMAX    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CW      = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_OPC, S_ADDR, S_READ,
    S_WDATA, S_DONE, S_ARM, S_END
  } state_t;

  logic [DATA_W-1:0] ram [WORDS];

  logic [1:0] scs_s, sclk_s, sdi_s;
  logic       sclk_q, scs_q;
  logic       rise, fall, sdi;

  state_t            state, state_n;
  logic [1:0]        op, op_n;
  logic [ADDR_W-1:0] addr, addr_n, a_full;
  logic [DATA_W-1:0] data, data_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              sdo, sdo_n;
  logic              wen, wen_n;

  logic              cm_word, cm_sweep;
  logic [ADDR_W-1:0] cm_addr;
  logic [DATA_W-1:0] cm_data;

  logic              pend;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;
  logic [ADDR_W:0]   sw_cnt;
  logic [DATA_W-1:0] sw_data;
  logic              sw_act;
  logic [BW-1:0]     busy_cnt;
  logic              busy;

  logic              ram_we, prot_we;
  logic [ADDR_W-1:0] ram_wa;
  logic [DATA_W-1:0] ram_wd;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      scs_s  <= '0;
      sclk_s <= '0;
      sdi_s  <= '0;
      sclk_q <= 1'b0;
      scs_q  <= 1'b0;
    end else begin
      scs_s  <= {scs_s[0], SCS};
      sclk_s <= {sclk_s[0], SCLK};
      sdi_s  <= {sdi_s[0], SDI};
      sclk_q <= sclk_s[1];
      scs_q  <= scs_s[1];
    end
  end

  assign rise   = sclk_s[1] & ~sclk_q;
  assign fall   = scs_q & ~scs_s[1];
  assign sdi    = sdi_s[1];
  assign a_full = {addr[ADDR_W-2:0], sdi};
  assign sw_act = ~sw_cnt[ADDR_W];
  assign busy   = (busy_cnt != '0) | pend | sw_act;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
      op    <= '0;
      addr  <= '0;
      data  <= '0;
      cnt   <= '0;
      sdo   <= 1'b1;
      wen   <= 1'b0;
    end else begin
      state <= state_n;
      op    <= op_n;
      addr  <= addr_n;
      data  <= data_n;
      cnt   <= cnt_n;
      sdo   <= sdo_n;
      wen   <= wen_n;
    end
  end

  always_comb begin
    state_n  = state;
    op_n     = op;
    addr_n   = addr;
    data_n   = data;
    cnt_n    = cnt;
    sdo_n    = ~busy;
    wen_n    = wen;
    cm_word  = 1'b0;
    cm_sweep = 1'b0;
    cm_addr  = addr;
    cm_data  = data;
    if (!scs_s[1]) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      sdo_n   = 1'b1;
      // Only fully received commands are still sitting in DONE/ARM here.
      if (fall && wen) begin
        if (state == S_DONE) begin
          cm_word  = (op == 2'b01);
          cm_sweep = (op != 2'b01);
        end else if (state == S_ARM) begin
          cm_data  = '1;
          cm_word  = (op == 2'b11);
          cm_sweep = (op != 2'b11);
        end
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rise && sdi && !busy) begin
            state_n = S_OPC;
            cnt_n   = '0;
          end
        end
        S_OPC: begin
          if (rise) begin
            op_n  = {op[0], sdi};
            cnt_n = cnt + 1'b1;
            if (cnt == CW'(1)) begin
              state_n = S_ADDR;
              cnt_n   = '0;
            end
          end
        end
        S_ADDR: begin
          if (rise) begin
            addr_n = a_full;
            cnt_n  = cnt + 1'b1;
            if (cnt == CW'(ADDR_W - 1)) begin
              cnt_n = '0;
              unique case (op)
                2'b10: begin
                  state_n = S_READ;
                  sdo_n   = 1'b0;
                  data_n  = ram[a_full];
                end
                2'b01: state_n = S_WDATA;
                2'b11: state_n = S_ARM;
                default: begin
                  unique case (a_full[ADDR_W-1 -: 2])
                    2'b11: begin
                      wen_n   = 1'b1;
                      state_n = S_END;
                    end
                    2'b00: begin
                      wen_n   = 1'b0;
                      state_n = S_END;
                    end
                    2'b10:   state_n = S_ARM;
                    default: state_n = S_WDATA;
                  endcase
                end
              endcase
            end
          end
        end
        S_READ: begin
          sdo_n = sdo;
          if (rise) begin
            if (cnt == CW'(DATA_W)) begin
              sdo_n   = 1'b1;
              state_n = S_END;
            end else begin
              sdo_n  = data[DATA_W-1];
              data_n = {data[DATA_W-2:0], 1'b0};
              cnt_n  = cnt + 1'b1;
            end
          end
        end
        S_WDATA: begin
          if (rise) begin
            data_n = {data[DATA_W-2:0], sdi};
            cnt_n  = cnt + 1'b1;
            if (cnt == CW'(DATA_W - 1)) begin
              state_n = S_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pend     <= 1'b0;
      p_addr   <= '0;
      p_data   <= '0;
      sw_cnt   <= {1'b1, {ADDR_W{1'b0}}};
      sw_data  <= '0;
      busy_cnt <= '0;
    end else begin
      if (busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
      if (pend && !NV_WE) pend <= 1'b0;
      if (sw_act && !NV_WE && !pend) sw_cnt <= sw_cnt + 1'b1;
      if (cm_word) begin
        pend     <= 1'b1;
        p_addr   <= cm_addr;
        p_data   <= cm_data;
        busy_cnt <= BW'(BUSY_CLKS);
      end
      if (cm_sweep) begin
        sw_cnt   <= '0;
        sw_data  <= cm_data;
        busy_cnt <= BW'(BUSY_SW);
      end
    end
  end

  // Single write port: the NV loader wins, protocol writes wait a CLK.
  always_comb begin
    ram_we  = 1'b0;
    prot_we = 1'b0;
    ram_wa  = NV_ADDR;
    ram_wd  = NV_DIN;
    if (NV_WE) begin
      ram_we = 1'b1;
    end else if (pend) begin
      ram_we  = 1'b1;
      prot_we = 1'b1;
      ram_wa  = p_addr;
      ram_wd  = p_data;
    end else if (sw_act) begin
      ram_we  = 1'b1;
      prot_we = 1'b1;
      ram_wa  = sw_cnt[ADDR_W-1:0];
      ram_wd  = sw_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) NV_DOUT <= '0;
    else          NV_DOUT <= ram[NV_ADDR];
  end

  assign SDO = sdo;

`ifdef EEPROM_DIRTY_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)     DIRTY <= 1'b0;
    else if (prot_we) DIRTY <= 1'b1;
    else if (NV_WE)   DIRTY <= 1'b0;
  end
`else
  logic unused_ok;
  assign unused_ok = prot_we;
`endif

endmodule
